// File: rtl/ccx_mem_arbiter.sv
// N-to-1 memory bus arbiter: round-robin or fixed-priority selection, with an optional
// response timeout that errors the stalled requestor and then drains the hung transaction.
module ccx_mem_arbiter #(
  parameter int NREQ    = 2,
  parameter int AW      = 39,
  parameter int DW      = 64,
  parameter int RR_EN   = 1,
  parameter int TIMEOUT = 0
) (
  input  logic                   g_clk,
  input  logic                   g_resetn,
  input  logic [NREQ-1:0]        s_req,
  input  logic [NREQ-1:0]        s_rtype,
  input  logic [NREQ*AW-1:0]     s_addr,
  input  logic [NREQ-1:0]        s_wen,
  input  logic [NREQ*DW/8-1:0]   s_strb,
  input  logic [NREQ*DW-1:0]     s_wdata,
  output logic [NREQ-1:0]        s_gnt,
  output logic [NREQ-1:0]        s_err,
  output logic [DW-1:0]          s_rdata,
  output logic                   m_req,
  output logic                   m_rtype,
  output logic [AW-1:0]          m_addr,
  output logic                   m_wen,
  output logic [DW/8-1:0]        m_strb,
  output logic [DW-1:0]          m_wdata,
  input  logic                   m_gnt,
  input  logic                   m_err,
  input  logic [DW-1:0]          m_rdata,
  output logic                   timeout
);

  localparam int SW = DW / 8;
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [15:0] TO_LAST = (TIMEOUT > 0) ? 16'(TIMEOUT - 1) : 16'd0;

  typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_t;

  state_t          state;
  logic [IW-1:0]   idx;
  logic [IW-1:0]   ptr;
  logic [15:0]     cnt;
  logic [IW-1:0]   win;
  logic [IW-1:0]   idx_inc;
  logic            to_hit;

  logic            cap_rtype;
  logic [AW-1:0]   cap_addr;
  logic            cap_wen;
  logic [SW-1:0]   cap_strb;
  logic [DW-1:0]   cap_wdata;

  logic [AW-1:0]   addr_arr  [NREQ];
  logic [SW-1:0]   strb_arr  [NREQ];
  logic [DW-1:0]   wdata_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign addr_arr[gi]  = s_addr[gi*AW +: AW];
    assign strb_arr[gi]  = s_strb[gi*SW +: SW];
    assign wdata_arr[gi] = s_wdata[gi*DW +: DW];
  end

  // Scan starts at ptr for round-robin, at port 0 for fixed priority.
  always_comb begin
    int  j;
    logic found;
    win   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (RR_EN != 0) ? ((int'(ptr) + k) % NREQ) : k;
      if (!found && s_req[j]) begin
        win   = IW'(j);
        found = 1'b1;
      end
    end
  end

  assign idx_inc = (int'(idx) == NREQ - 1) ? '0 : idx + 1'b1;

  // A grant arriving in the last allowed cycle beats the timeout.
  assign to_hit = (TIMEOUT != 0) && (state == BUSY) && !m_gnt && (cnt == TO_LAST);

  always_comb begin
    s_gnt   = '0;
    s_err   = '0;
    s_rdata = '0;
    m_req   = 1'b0;
    m_rtype = 1'b0;
    m_addr  = '0;
    m_wen   = 1'b0;
    m_strb  = '0;
    m_wdata = '0;
    timeout = to_hit;
    case (state)
      BUSY: begin
        m_req   = s_req[idx];
        m_rtype = s_rtype[idx];
        m_addr  = addr_arr[idx];
        m_wen   = s_wen[idx];
        m_strb  = strb_arr[idx];
        m_wdata = wdata_arr[idx];
        if (to_hit) begin
          s_gnt[idx] = 1'b1;
          s_err[idx] = 1'b1;
        end else begin
          s_gnt[idx] = m_gnt;
          s_err[idx] = m_err;
          s_rdata    = m_rdata;
        end
      end
      ABORT: begin
        m_req   = 1'b1;
        m_rtype = cap_rtype;
        m_addr  = cap_addr;
        m_wen   = cap_wen;
        m_strb  = cap_strb;
        m_wdata = cap_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state     <= IDLE;
      idx       <= '0;
      ptr       <= '0;
      cnt       <= '0;
      cap_rtype <= 1'b0;
      cap_addr  <= '0;
      cap_wen   <= 1'b0;
      cap_strb  <= '0;
      cap_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|s_req) begin
            idx   <= win;
            cnt   <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (m_gnt) begin
            state <= IDLE;
            ptr   <= idx_inc;
          end else if (to_hit) begin
            // The requestor is released now; the responder still owes a response.
            state     <= ABORT;
            ptr       <= idx_inc;
            cap_rtype <= s_rtype[idx];
            cap_addr  <= addr_arr[idx];
            cap_wen   <= s_wen[idx];
            cap_strb  <= strb_arr[idx];
            cap_wdata <= wdata_arr[idx];
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ABORT: begin
          if (m_gnt) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ccx_mem_arbiter.sv
// Bench for ccx_mem_arbiter: directed scenarios plus randomized traffic checked against
// a transaction-level model of the arbitration and timeout rules.
module tb_ccx_mem_arbiter;

  localparam int AW = 39;
  localparam int DW = 64;
  localparam int SW = DW / 8;
  localparam int FW = 1 + AW + 1 + SW + DW;

  logic g_clk = 1'b0;
  logic g_resetn = 1'b0;
  logic [1:0]      s_req = '0, s_rtype = '0, s_wen = '0;
  logic [2*AW-1:0] s_addr = '0;
  logic [2*SW-1:0] s_strb = '0;
  logic [2*DW-1:0] s_wdata = '0;
  logic            m_gnt = 1'b0, m_err = 1'b0;
  logic [DW-1:0]   m_rdata = '0;

  logic [1:0]    a_s_gnt, a_s_err, b_s_gnt, b_s_err;
  logic [DW-1:0] a_s_rdata, b_s_rdata, a_m_wdata, b_m_wdata;
  logic          a_m_req, a_m_rtype, a_m_wen, a_timeout;
  logic          b_m_req, b_m_rtype, b_m_wen, b_timeout;
  logic [AW-1:0] a_m_addr, b_m_addr;
  logic [SW-1:0] a_m_strb, b_m_strb;
  logic [FW-1:0] a_fields, b_fields;

  logic          f_rtype [2];
  logic [AW-1:0] f_addr  [2];
  logic          f_wen   [2];
  logic [SW-1:0] f_strb  [2];
  logic [DW-1:0] f_wdata [2];

  int total = 0;
  int bad   = 0;

  always #5 g_clk = ~g_clk;

  ccx_mem_arbiter #(.NREQ(2), .AW(AW), .DW(DW), .RR_EN(1), .TIMEOUT(8)) dut_a (
    .g_clk(g_clk), .g_resetn(g_resetn), .s_req(s_req), .s_rtype(s_rtype), .s_addr(s_addr),
    .s_wen(s_wen), .s_strb(s_strb), .s_wdata(s_wdata), .s_gnt(a_s_gnt), .s_err(a_s_err),
    .s_rdata(a_s_rdata), .m_req(a_m_req), .m_rtype(a_m_rtype), .m_addr(a_m_addr),
    .m_wen(a_m_wen), .m_strb(a_m_strb), .m_wdata(a_m_wdata), .m_gnt(m_gnt), .m_err(m_err),
    .m_rdata(m_rdata), .timeout(a_timeout));

  ccx_mem_arbiter #(.NREQ(2), .AW(AW), .DW(DW), .RR_EN(0), .TIMEOUT(0)) dut_b (
    .g_clk(g_clk), .g_resetn(g_resetn), .s_req(s_req), .s_rtype(s_rtype), .s_addr(s_addr),
    .s_wen(s_wen), .s_strb(s_strb), .s_wdata(s_wdata), .s_gnt(b_s_gnt), .s_err(b_s_err),
    .s_rdata(b_s_rdata), .m_req(b_m_req), .m_rtype(b_m_rtype), .m_addr(b_m_addr),
    .m_wen(b_m_wen), .m_strb(b_m_strb), .m_wdata(b_m_wdata), .m_gnt(m_gnt), .m_err(m_err),
    .m_rdata(m_rdata), .timeout(b_timeout));

  assign a_fields = {a_m_rtype, a_m_addr, a_m_wen, a_m_strb, a_m_wdata};
  assign b_fields = {b_m_rtype, b_m_addr, b_m_wen, b_m_strb, b_m_wdata};

  // Requestor protocol: a request may only be withdrawn after it was granted by dut_a.
  logic [1:0] held = '0;
  always @(posedge g_clk) begin
    if (!g_resetn) begin
      held <= '0;
    end else begin
      for (int i = 0; i < 2; i++)
        assert (!(held[i] && !s_req[i])) else $error("protocol: port %0d dropped req before gnt", i);
      held <= s_req & ~a_s_gnt;
    end
  end

  function automatic logic [FW-1:0] port_fields(input int i);
    return {f_rtype[i], f_addr[i], f_wen[i], f_strb[i], f_wdata[i]};
  endfunction

  task automatic drive_fields();
    for (int i = 0; i < 2; i++) begin
      s_rtype[i]            = f_rtype[i];
      s_addr[i*AW +: AW]    = f_addr[i];
      s_wen[i]              = f_wen[i];
      s_strb[i*SW +: SW]    = f_strb[i];
      s_wdata[i*DW +: DW]   = f_wdata[i];
    end
  endtask

  task automatic new_fields(input int i);
    f_rtype[i] = 1'($urandom);
    f_addr[i]  = AW'({$urandom, $urandom});
    f_wen[i]   = 1'($urandom);
    f_strb[i]  = SW'($urandom);
    f_wdata[i] = {$urandom, $urandom};
  endtask

  task automatic do_reset();
    g_resetn = 1'b0;
    s_req = '0; m_gnt = 1'b0; m_err = 1'b0; m_rdata = '0;
    @(negedge g_clk);
    @(negedge g_clk);
    g_resetn = 1'b1;
  endtask

  task automatic test_reset();
    g_resetn = 1'b0;
    s_req = 2'b11; m_gnt = 1'b1; m_err = 1'b1; m_rdata = {$urandom, $urandom};
    new_fields(0); new_fields(1); drive_fields();
    for (int c = 0; c < 2; c++) begin
      #1;
      total++;
      if ({a_m_req, a_s_gnt, a_s_err, a_timeout, b_m_req, b_s_gnt, b_s_err} !== '0) begin
        bad++;
        $display("FAIL reset_outputs got=%b want=0", {a_m_req, a_s_gnt, a_s_err, a_timeout, b_m_req, b_s_gnt, b_s_err});
      end
      total++;
      if (a_s_rdata !== '0) begin bad++; $display("FAIL reset_rdata got=%h want=0", a_s_rdata); end
      @(negedge g_clk);
    end
    g_resetn = 1'b1; s_req = '0; m_gnt = 1'b0; m_err = 1'b0;
    #1;
    total++;
    if (a_m_req !== 1'b0) begin bad++; $display("FAIL reset_release_mreq got=%b want=0", a_m_req); end
    $display("test_reset done");
    @(negedge g_clk);
  endtask

  task automatic test_single_read();
    logic [DW-1:0] rd;
    do_reset();
    f_rtype[0] = 1'b0; f_addr[0] = AW'(64'h40); f_wen[0] = 1'b0; f_strb[0] = '0; f_wdata[0] = '0;
    drive_fields();
    s_req = 2'b01;
    #1;
    total++;
    if (a_m_req !== 1'b0) begin bad++; $display("FAIL read_idle_mreq got=%b want=0", a_m_req); end
    @(negedge g_clk);
    for (int k = 0; k < 4; k++) begin
      rd = (k == 3) ? 64'hDEADBEEF : {$urandom, $urandom};
      m_gnt = (k == 3); m_rdata = rd;
      #1;
      total++;
      if ({a_m_req, a_m_addr} !== {1'b1, f_addr[0]}) begin
        bad++; $display("FAIL read_mreq_addr cyc=%0d got=%b/%h want=1/%h", k, a_m_req, a_m_addr, f_addr[0]);
      end
      total++;
      if (a_s_gnt !== ((k == 3) ? 2'b01 : 2'b00)) begin
        bad++; $display("FAIL read_sgnt cyc=%0d got=%b want=%b", k, a_s_gnt, (k == 3) ? 2'b01 : 2'b00);
      end
      if (k == 3) begin
        total++;
        if (a_s_rdata !== 64'hDEADBEEF) begin bad++; $display("FAIL read_rdata got=%h want=deadbeef", a_s_rdata); end
      end
      @(negedge g_clk);
    end
    s_req = '0; m_gnt = 1'b0;
    #1;
    total++;
    if ({a_m_req, a_s_gnt} !== 3'b000) begin bad++; $display("FAIL read_back_idle got=%b want=000", {a_m_req, a_s_gnt}); end
    $display("test_single_read done");
    @(negedge g_clk);
  endtask

  task automatic test_round_robin();
    int order [4] = '{0, 1, 0, 1};
    int exp_port;
    do_reset();
    new_fields(0); new_fields(1); drive_fields();
    s_req = 2'b11;
    for (int c = 0; c < 8; c++) begin
      m_gnt = (c % 2 == 1); m_rdata = {$urandom, $urandom};
      #1;
      if (c % 2 == 0) begin
        total++;
        if ({a_m_req, a_s_gnt} !== 3'b000) begin bad++; $display("FAIL rr_bubble cyc=%0d got=%b want=000", c, {a_m_req, a_s_gnt}); end
      end else begin
        exp_port = order[c / 2];
        total++;
        if (a_s_gnt !== (2'b01 << exp_port)) begin
          bad++; $display("FAIL rr_order cyc=%0d got=%b want=%b", c, a_s_gnt, 2'b01 << exp_port);
        end
        total++;
        if (a_fields !== port_fields(exp_port)) begin bad++; $display("FAIL rr_fields cyc=%0d got=%h want=%h", c, a_fields, port_fields(exp_port)); end
      end
      @(negedge g_clk);
    end
    $display("test_round_robin done");
  endtask

  task automatic test_fixed_priority();
    do_reset();
    new_fields(0); new_fields(1); drive_fields();
    s_req = 2'b11;
    for (int c = 0; c < 10; c++) begin
      m_gnt = (c % 2 == 1);
      #1;
      total++;
      if (b_s_gnt !== ((c % 2 == 1) ? 2'b01 : 2'b00)) begin
        bad++; $display("FAIL fp_gnt cyc=%0d got=%b want=%b", c, b_s_gnt, (c % 2 == 1) ? 2'b01 : 2'b00);
      end
      if (c % 2 == 1) begin
        total++;
        if (b_fields !== port_fields(0)) begin bad++; $display("FAIL fp_fields cyc=%0d got=%h want=%h", c, b_fields, port_fields(0)); end
      end
      @(negedge g_clk);
    end
    $display("test_fixed_priority done");
  endtask

  task automatic test_timeout();
    logic [FW-1:0] cap;
    do_reset();
    new_fields(0);
    f_rtype[1] = 1'b1; f_addr[1] = AW'(64'h1000); f_wen[1] = 1'b1; f_strb[1] = '1; f_wdata[1] = {$urandom, $urandom};
    drive_fields();
    cap = port_fields(1);
    s_req = 2'b10;
    #1;
    total++;
    if (a_m_req !== 1'b0) begin bad++; $display("FAIL to_idle_mreq got=%b want=0", a_m_req); end
    @(negedge g_clk);
    for (int b = 1; b <= 8; b++) begin
      s_req = 2'b11; m_gnt = 1'b0; m_rdata = {$urandom, $urandom} | 64'h1;
      #1;
      total++;
      if ({a_m_req, a_fields} !== {1'b1, cap}) begin bad++; $display("FAIL to_busy_req cyc=%0d got=%h want=%h", b, a_fields, cap); end
      total++;
      if ({a_s_gnt, a_s_err, a_timeout} !== ((b == 8) ? 5'b10101 : 5'b00000)) begin
        bad++; $display("FAIL to_pulse cyc=%0d got=%b want=%b", b, {a_s_gnt, a_s_err, a_timeout}, (b == 8) ? 5'b10101 : 5'b00000);
      end
      if (b == 8) begin
        total++;
        if (a_s_rdata !== '0) begin bad++; $display("FAIL to_rdata got=%h want=0", a_s_rdata); end
      end
      @(negedge g_clk);
    end
    s_req = 2'b01;
    f_addr[1] = AW'(64'h2222); f_wen[1] = 1'b0; drive_fields();
    for (int c = 9; c <= 20; c++) begin
      m_gnt = (c == 20); m_err = 1'b1; m_rdata = {$urandom, $urandom};
      #1;
      total++;
      if ({a_m_req, a_fields} !== {1'b1, cap}) begin bad++; $display("FAIL to_drain_req cyc=%0d got=%h want=%h", c, a_fields, cap); end
      total++;
      if ({a_s_gnt, a_s_err, a_timeout} !== 5'b00000) begin bad++; $display("FAIL to_drain_quiet cyc=%0d got=%b want=0", c, {a_s_gnt, a_s_err, a_timeout}); end
      @(negedge g_clk);
    end
    m_gnt = 1'b0; m_err = 1'b0;
    #1;
    total++;
    if (a_m_req !== 1'b0) begin bad++; $display("FAIL to_after_idle got=%b want=0", a_m_req); end
    @(negedge g_clk);
    m_gnt = 1'b1;
    #1;
    total++;
    if ({a_m_req, a_s_gnt, a_fields} !== {1'b1, 2'b01, port_fields(0)}) begin
      bad++; $display("FAIL to_next_port0 got=%b/%h want=1,01/%h", a_s_gnt, a_fields, port_fields(0));
    end
    @(negedge g_clk);
    s_req = '0; m_gnt = 1'b0;
    $display("test_timeout done");
  endtask

  task automatic test_timeout_boundary();
    logic [DW-1:0] rd;
    do_reset();
    new_fields(0); drive_fields();
    s_req = 2'b01;
    @(negedge g_clk);
    for (int b = 1; b <= 8; b++) begin
      rd = {$urandom, $urandom};
      m_gnt = (b == 8); m_err = 1'b0; m_rdata = rd;
      #1;
      total++;
      if ({a_s_gnt, a_s_err, a_timeout} !== ((b == 8) ? 5'b01000 : 5'b00000)) begin
        bad++; $display("FAIL bnd_resp cyc=%0d got=%b want=%b", b, {a_s_gnt, a_s_err, a_timeout}, (b == 8) ? 5'b01000 : 5'b00000);
      end
      if (b == 8) begin
        total++;
        if (a_s_rdata !== rd) begin bad++; $display("FAIL bnd_rdata got=%h want=%h", a_s_rdata, rd); end
      end
      @(negedge g_clk);
    end
    s_req = '0; m_gnt = 1'b0;
    #1;
    total++;
    if ({a_m_req, a_timeout} !== 2'b00) begin bad++; $display("FAIL bnd_no_abort got=%b want=00", {a_m_req, a_timeout}); end
    $display("test_timeout_boundary done");
    @(negedge g_clk);
  endtask

  task automatic test_err_reset();
    do_reset();
    new_fields(0); new_fields(1); drive_fields();
    s_req = 2'b10;
    @(negedge g_clk);
    m_gnt = 1'b1; m_err = 1'b1;
    #1;
    total++;
    if ({a_s_gnt, a_s_err} !== 4'b1010) begin bad++; $display("FAIL err_resp got=%b want=1010", {a_s_gnt, a_s_err}); end
    @(negedge g_clk);
    s_req = 2'b01; m_gnt = 1'b0; m_err = 1'b0;
    @(negedge g_clk);
    m_gnt = 1'b1;
    #1;
    total++;
    if (a_s_gnt !== 2'b01) begin bad++; $display("FAIL err_port0 got=%b want=01", a_s_gnt); end
    @(negedge g_clk);
    s_req = 2'b10; m_gnt = 1'b0;
    @(negedge g_clk);
    #1;
    total++;
    if (a_m_req !== 1'b1) begin bad++; $display("FAIL err_busy_again got=%b want=1", a_m_req); end
    #1;
    m_gnt = 1'b1; g_resetn = 1'b0;
    #1;
    total++;
    if ({a_m_req, a_s_gnt} !== 3'b000) begin bad++; $display("FAIL err_async_reset got=%b want=000", {a_m_req, a_s_gnt}); end
    @(negedge g_clk);
    g_resetn = 1'b1; m_gnt = 1'b0; s_req = 2'b11;
    @(negedge g_clk);
    #1;
    total++;
    if ({a_m_req, a_fields} !== {1'b1, port_fields(0)}) begin bad++; $display("FAIL err_ptr_cleared got=%h want=%h", a_fields, port_fields(0)); end
    $display("test_err_reset done");
    @(negedge g_clk);
    s_req = '0;
  endtask

  task automatic test_random(input int ntx);
    logic [1:0]    pend;
    int            ptr_m, w, lat, dlat;
    logic          fin_g, fin_t, err_bit;
    logic [1:0]    exp_gnt, exp_err;
    logic [DW-1:0] rd;
    logic [FW-1:0] cap;
    do_reset();
    pend = '0; ptr_m = 0;
    for (int t = 0; t < ntx; t++) begin
      for (int i = 0; i < 2; i++)
        if (!pend[i] && $urandom_range(0, 2) != 0) begin pend[i] = 1'b1; new_fields(i); end
      if (pend == 2'b00) begin w = $urandom_range(0, 1); pend[w] = 1'b1; new_fields(w); end
      s_req = pend; drive_fields(); m_gnt = 1'b0; m_err = 1'b0;
      // Round-robin: the pointer port if requesting, otherwise the other one.
      w = pend[ptr_m] ? ptr_m : 1 - ptr_m;
      #1;
      total++;
      if ({a_m_req, a_s_gnt} !== 3'b000) begin bad++; $display("FAIL rnd_idle tx=%0d got=%b want=000", t, {a_m_req, a_s_gnt}); end
      @(negedge g_clk);
      lat = $urandom_range(0, 11);
      for (int k = 0; k < 8; k++) begin
        fin_g = (k == lat);
        fin_t = (k == 7) && (lat > 7);
        err_bit = 1'($urandom); rd = {$urandom, $urandom};
        m_gnt = fin_g; m_err = fin_g ? err_bit : 1'b0; m_rdata = rd;
        exp_gnt = (fin_g || fin_t) ? (2'b01 << w) : 2'b00;
        exp_err = (fin_t || (fin_g && err_bit)) ? (2'b01 << w) : 2'b00;
        #1;
        total++;
        if ({a_m_req, a_fields} !== {1'b1, port_fields(w)}) begin
          bad++; $display("FAIL rnd_req tx=%0d k=%0d got=%b/%h want=1/%h", t, k, a_m_req, a_fields, port_fields(w));
        end
        total++;
        if ({a_s_gnt, a_s_err, a_timeout} !== {exp_gnt, exp_err, fin_t}) begin
          bad++; $display("FAIL rnd_resp tx=%0d k=%0d got=%b want=%b", t, k, {a_s_gnt, a_s_err, a_timeout}, {exp_gnt, exp_err, fin_t});
        end
        if (fin_g || fin_t) begin
          total++;
          if (a_s_rdata !== (fin_t ? '0 : rd)) begin bad++; $display("FAIL rnd_rdata tx=%0d got=%h want=%h", t, a_s_rdata, fin_t ? '0 : rd); end
        end
        @(negedge g_clk);
        if (fin_g || fin_t) break;
      end
      cap = port_fields(w);
      pend[w] = 1'b0;
      ptr_m = (w + 1) % 2;
      if (lat > 7) begin
        dlat = $urandom_range(0, 5);
        for (int d = 0; d <= dlat; d++) begin
          for (int i = 0; i < 2; i++)
            if (!pend[i] && $urandom_range(0, 3) == 0) begin pend[i] = 1'b1; new_fields(i); end
          s_req = pend; drive_fields();
          m_gnt = (d == dlat); m_err = 1'($urandom); m_rdata = {$urandom, $urandom};
          #1;
          total++;
          if ({a_m_req, a_fields} !== {1'b1, cap}) begin bad++; $display("FAIL rnd_drain tx=%0d d=%0d got=%h want=%h", t, d, a_fields, cap); end
          total++;
          if ({a_s_gnt, a_s_err, a_timeout} !== 5'b00000) begin bad++; $display("FAIL rnd_drain_quiet tx=%0d got=%b want=0", t, {a_s_gnt, a_s_err, a_timeout}); end
          @(negedge g_clk);
        end
      end
      $display("rnd tx=%0d port=%0d lat=%0d timeout=%0d", t, w, lat, lat > 7);
    end
    s_req = '0; m_gnt = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_fixed_priority();
    test_timeout();
    test_timeout_boundary();
    test_err_reset();
    test_random(150);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
